// File: rtl/mux_rr.sv
// mux_rr: round-robin N:1 word multiplexer with bounded bursts.
//
// A channel that wins arbitration keeps the output for up to MAX_BURST
// consecutive words while other channels compete. It keeps the output for
// longer only when no other channel is valid. Words land in a single output
// register, one cycle after the source sees its pop pulse.
//
// Ports:
//   clk          - clock, rising edge
//   reset        - synchronous, active-high
//   data_in_c    - packed channel words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_in_c   - per-channel word valid
//   ready_in_c   - downstream ready; all state holds while low
//   data_out_c   - registered output word
//   valid_out_c  - registered output valid
//   grant_out_c  - registered index of the channel that sourced data_out_c
//   pop_out_c    - combinational one-hot consume strobe back to the sources
module mux_rr #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in_c,
    input  logic [NUM_CH-1:0]            valid_in_c,
    input  logic                         ready_in_c,
    output logic [DATA_WIDTH-1:0]        data_out_c,
    output logic                         valid_out_c,
    output logic [GW-1:0]                grant_out_c,
    output logic [NUM_CH-1:0]            pop_out_c
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [GW-1:0]  cur;
    logic [GW-1:0]  last;
    logic [CW-1:0]  cnt;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] words;
    assign words = data_in_c;

    logic              any_vld;
    logic [NUM_CH-1:0] others;
    logic [GW-1:0]     start;
    logic [GW-1:0]     srch;
    logic [GW-1:0]     sel;
    logic [GW-1:0]     idx;
    logic              found;
    logic              keep;
    logic              take;
    int                idx_i;

    // The search begins one past the reference index and wraps around. The
    // reference index is therefore the last candidate considered: it is
    // last-served when idle and the held channel while granting.
    always_comb begin
        any_vld = |valid_in_c;
        others  = valid_in_c & ~(NUM_CH'(1) << cur);
        start   = (state == IDLE) ? last : cur;
        found   = 1'b0;
        srch    = '0;
        idx     = '0;
        idx_i   = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx_i = (int'(start) + k) % NUM_CH;
            idx   = GW'(idx_i);
            if (!found && valid_in_c[idx]) begin
                found = 1'b1;
                srch  = idx;
            end
        end
        // Stay on the held channel until its burst budget is spent. Stay
        // longer only if nobody else is waiting.
        keep = (state == GRANT) && valid_in_c[cur] &&
               ((cnt < MAXB) || (others == '0));
        sel  = keep ? cur : srch;
        take = ready_in_c && any_vld && !reset;
        pop_out_c = take ? (NUM_CH'(1) << sel) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_c  <= '0;
            valid_out_c <= 1'b0;
            grant_out_c <= '0;
            state       <= IDLE;
            cnt         <= '0;
            cur         <= '0;
            last        <= GW'(NUM_CH - 1);
        end else if (ready_in_c) begin
            if (any_vld) begin
                data_out_c  <= words[sel];
                valid_out_c <= 1'b1;
                grant_out_c <= sel;
                cur         <= sel;
                last        <= sel;
                state       <= GRANT;
                if (keep)
                    cnt <= (cnt == MAXB) ? cnt : cnt + CW'(1);
                else
                    cnt <= CW'(1);
            end else begin
                // Nothing to send. Data, grant and last hold, so the next
                // search resumes after the channel that was served last.
                valid_out_c <= 1'b0;
                state       <= IDLE;
                cnt         <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr.sv
// Directed bench for mux_rr. One instance uses MAX_BURST=4 and a second
// instance uses MAX_BURST=1. Both instances share all inputs.
module tb_mux_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in_c;
    logic [3:0]  valid_in_c;
    logic        ready_in_c;

    logic [7:0]  data_out_c,  data_out_1;
    logic        valid_out_c, valid_out_1;
    logic [1:0]  grant_out_c, grant_out_1;
    logic [3:0]  pop_out_c,   pop_out_1;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] w [4];
    int         exp_seq [9];

    mux_rr #(.NUM_CH(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .data_in_c(data_in_c), .valid_in_c(valid_in_c),
        .ready_in_c(ready_in_c), .data_out_c(data_out_c), .valid_out_c(valid_out_c),
        .grant_out_c(grant_out_c), .pop_out_c(pop_out_c)
    );

    mux_rr #(.NUM_CH(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset(reset), .data_in_c(data_in_c), .valid_in_c(valid_in_c),
        .ready_in_c(ready_in_c), .data_out_c(data_out_1), .valid_out_c(valid_out_1),
        .grant_out_c(grant_out_1), .pop_out_c(pop_out_1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge. Inputs are
    // driven at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input int ch, input logic v);
        chk({tag, ".valid"}, 32'(valid_out_c), 32'(v));
        chk({tag, ".grant"}, 32'(grant_out_c), 32'(ch));
        chk({tag, ".data"},  32'(data_out_c),  32'(w[ch]));
    endtask

    initial begin
        w[0] = 8'hA5; w[1] = 8'hB1; w[2] = 8'hC2; w[3] = 8'hD3;
        data_in_c  = {w[3], w[2], w[1], w[0]};
        reset      = 1'b1;
        valid_in_c = 4'b1111;
        ready_in_c = 1'b1;
        #1;
        chk("rst.pop", 32'(pop_out_c), 32'h0);
        tick();
        chk("rst.valid", 32'(valid_out_c), 32'h0);
        chk("rst.grant", 32'(grant_out_c), 32'h0);
        chk("rst.data",  32'(data_out_c),  32'h0);
        chk("rst.pop2",  32'(pop_out_c),   32'h0);

        // Two channels valid with bursts of 4, then the grant alternates.
        reset = 1'b0; valid_in_c = 4'b0101;
        exp_seq = '{0, 0, 0, 0, 2, 2, 2, 2, 0};
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("alt.pop", 32'(pop_out_c), 32'(4'b0001 << exp_seq[i]));
            tick();
            outs("alt", exp_seq[i], 1'b1);
        end

        // Only ch1 is valid. Expect ten ch1 words with no switch and no bubble.
        valid_in_c = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("solo.pop", 32'(pop_out_c), 32'h2);
            tick();
            outs("solo", 1, 1'b1);
        end
        valid_in_c = 4'b0000;
        #1;
        chk("drain.pop", 32'(pop_out_c), 32'h0);
        tick();
        outs("drain", 1, 1'b0);

        // Serve ch2, go idle, then the search resumes from 3 and wraps to 0.
        valid_in_c = 4'b0100;
        #1;
        chk("ch2.pop", 32'(pop_out_c), 32'h4);
        tick();
        outs("ch2", 2, 1'b1);
        valid_in_c = 4'b0000;
        tick();
        outs("ch2idle", 2, 1'b0);
        valid_in_c = 4'b0101;
        #1;
        chk("wrap.pop", 32'(pop_out_c), 32'h1);
        tick();
        outs("wrap", 0, 1'b1);

        // Stall in the middle of a ch0 burst while cnt=2. The remaining budget
        // must be 2 more words.
        #1;
        chk("pre.pop", 32'(pop_out_c), 32'h1);
        tick();
        ready_in_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.pop", 32'(pop_out_c), 32'h0);
            tick();
            outs("stall", 0, 1'b1);
        end
        ready_in_c = 1'b1;
        exp_seq = '{0, 0, 2, 2, 2, 2, 2, 2, 2};
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("resume.pop", 32'(pop_out_c), 32'(4'b0001 << exp_seq[i]));
            tick();
            outs("resume", exp_seq[i], 1'b1);
        end

        // Reset in the middle of a ch3 burst. The first grant after reset is ch0.
        valid_in_c = 4'b1001;
        #1;
        chk("ch3.pop", 32'(pop_out_c), 32'h8);
        tick();
        outs("ch3", 3, 1'b1);
        tick();
        reset = 1'b1;
        #1;
        chk("rst3.pop", 32'(pop_out_c), 32'h0);
        tick();
        chk("rst3.valid", 32'(valid_out_c), 32'h0);
        chk("rst3.grant", 32'(grant_out_c), 32'h0);
        chk("rst3.data",  32'(data_out_c),  32'h0);
        reset = 1'b0;
        #1;
        chk("post.pop", 32'(pop_out_c), 32'h1);
        tick();
        outs("post", 0, 1'b1);

        // With MAX_BURST=1, the grant rotates strictly among all four channels.
        reset = 1'b1;
        tick();
        reset = 1'b0; valid_in_c = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr1.pop", 32'(pop_out_1), 32'(4'b0001 << (i % 4)));
            tick();
            chk("rr1.grant", 32'(grant_out_1), 32'(i % 4));
            chk("rr1.data",  32'(data_out_1),  32'(w[i % 4]));
            chk("rr1.valid", 32'(valid_out_1), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
